// File: rtl/cdb_result_buffer.sv
// rtl/cdb_result_buffer.sv - per-FU completion FIFO feeding the CDB arbiter
//
// Captures finished FU results (tag + data) into a small circular FIFO and
// raises one CDB request per buffered result. It presents the head entry
// combinationally on the grant cycle, and back-pressures the FU when the
// FIFO is full.
//
// Optional feature: define CDB_RESULT_BUFFER_BYPASS_EN to let request_out
// also assert in the arrival cycle of a push into an empty buffer. The
// entry is still written to the FIFO and is popped from head on the
// following (grant) cycle.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   squash            flush; discards every buffered result
//   fu_valid_in       FU result valid this cycle
//   fu_tag_in         destination physical tag
//   fu_data_in        result value
//   fu_ready_out      buffer can accept a result this cycle
//   request_out       CDB request to the arbiter
//   grant_in          registered CDB grant (one cycle after request)
//   cdb_valid_out     result presented to the CDB mux (grant cycle)
//   cdb_tag_out       presented tag (0 when not presenting)
//   cdb_data_out      presented data (0 when not presenting)
//   count_out         occupancy (debug)
module cdb_result_buffer #(
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     squash,
   input  logic                     fu_valid_in,
   input  logic [TAG_W-1:0]         fu_tag_in,
   input  logic [DATA_W-1:0]        fu_data_in,
   output logic                     fu_ready_out,
   output logic                     request_out,
   input  logic                     grant_in,
   output logic                     cdb_valid_out,
   output logic [TAG_W-1:0]         cdb_tag_out,
   output logic [DATA_W-1:0]        cdb_data_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [TAG_W-1:0]  tag_d  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              pending_gnt_q, pending_gnt_d;

   logic              push;
   logic              pop;

   // Handshake and presentation, all from registered state plus this
   // cycle's inputs. Ready deliberately ignores a same-cycle pop.
   always_comb begin
      fu_ready_out = (count_q < CW'(DEPTH));
      push         = fu_valid_in && fu_ready_out;
      pop          = grant_in && (count_q != '0);

      // The entry being granted now is already in flight, so only request
      // for what remains after this cycle's pop.
      request_out  = ((count_q - CW'(pop)) != '0);
`ifdef CDB_RESULT_BUFFER_BYPASS_EN
      request_out  = request_out || ((count_q == '0) && push);
`endif

      cdb_valid_out = pop;
      cdb_tag_out   = pop ? tag_q[head_q]  : '0;
      cdb_data_out  = pop ? data_q[head_q] : '0;
      count_out     = count_q;
   end

   // Next-state: squash wins over any same-cycle push or pop.
   always_comb begin
      tag_d         = tag_q;
      data_d        = data_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      pending_gnt_d = request_out;

      if (squash) begin
         head_d        = '0;
         tail_d        = '0;
         count_d       = '0;
         pending_gnt_d = 1'b0;
      end else begin
         if (push) begin
            tag_d[tail_q]  = fu_tag_in;
            data_d[tail_q] = fu_data_in;
            tail_d         = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         pending_gnt_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         pending_gnt_q <= pending_gnt_d;
         tag_q         <= tag_d;
         data_q        <= data_d;
      end
   end

   // Protocol checks: a result offered while full is lost, and a grant
   // must follow a request and find something to present.
   always_ff @(posedge clock) begin
      if (!reset && !squash) begin
         assert (!(fu_valid_in && !fu_ready_out))
            else $warning("result dropped while buffer full, tag %0h", fu_tag_in);
         assert (!(grant_in && (count_q == '0)))
            else $warning("spurious grant with empty buffer");
         assert (!grant_in || pending_gnt_q || (count_q == '0))
            else $warning("grant without a preceding request");
      end
   end

endmodule

// File: doc/cdb_result_buffer.md
Name: cdb_result_buffer

Overview:
- Per-FU completion buffer that sits directly upstream of the CDB arbiter/broadcast stage.
- Captures finished FU results (physical tag + data) into a small FIFO and raises one CDB request per buffered result.
- Presents the head entry on the grant cycle and back-pressures the FU's issue slot when full.
- One instance per FU; requests/grants map one-to-one onto that FU's FU_REQUESTS/FU_GRANTS bit.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- TAG_W, 6, physical register tag width.
- DATA_W, 32, result data width.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- squash  input  1  mispredict flush; discards all buffered results.
- fu_valid_in  input  1  FU result valid this cycle.
- fu_tag_in  input  TAG_W  destination physical tag.
- fu_data_in  input  DATA_W  result value.
- fu_ready_out  output  1  buffer can accept a result this cycle.
- request_out  output  1  CDB request to the arbiter.
- grant_in  input  1  registered CDB grant for this FU (arrives the cycle after the request).
- cdb_valid_out  output  1  result presented to the CDB mux.
- cdb_tag_out  output  TAG_W  presented tag.
- cdb_data_out  output  DATA_W  presented data.
- count_out  output  $clog2(DEPTH)+1  occupancy (debug).

Behaviour:
- Storage is a circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Reset, or squash, on the clock edge:
  - count, head and tail go to 0 and all entries are invalidated.
  - squash has priority over a same-cycle push or pop.
  - After reset: count_out=0, request_out=0, cdb_valid_out=0, cdb_tag_out=0, cdb_data_out=0, fu_ready_out=1.
- fu_ready_out = (count < DEPTH). It is combinational from registered count and does not credit a same-cycle pop.
- push = fu_valid_in && fu_ready_out. The entry is written at tail and becomes visible next cycle.
- fu_valid_in while not ready: the result is dropped, state is unchanged, and a simulation assertion fires.
- pop = grant_in && (count != 0).
- Presentation is combinational on the grant cycle:
  - cdb_valid_out = pop.
  - cdb_tag_out and cdb_data_out = head entry when pop, else 0.
  - The CDB registers these, so the broadcast is visible one cycle later.
- grant_in with count==0 is spurious: cdb_valid_out=0, no state change, assertion fires.
- Request timing:
  - Grant returns one cycle after request, so request_out must not re-request an entry already in flight.
  - request_out = (count - pop) != 0. It asserts only for the entry that will be head on the cycle its grant arrives.
  - pending_gnt is a 1-bit register set when request_out is asserted and cleared otherwise.
  - If pending_gnt=1 and grant_in=0 (arbitration lost), the entry stays and request_out remains asserted.
- Occupancy update:
  - Simultaneous push and pop: count unchanged; head and tail both advance.
  - Push only: count+1. Pop only: count-1.
- Latency: result in at cycle t → earliest request at t+1 → grant/presentation at t+2 → CDB broadcast at t+3.
- Ordering: results leave in arrival order; no reordering.

Optional Feature:
- Macro: CDB_RESULT_BUFFER_BYPASS_EN.
- Defined: request_out additionally asserts when count==0 and push in the same cycle.
  - This lets arbitration start in the arrival cycle.
  - The entry is still written to the FIFO, and the granted result is popped from head on the following cycle.
  - Latency is in at t → grant/presentation at t+1.
- Undefined: request_out is derived purely from registered state, with the timing above.

Test Plan:
- Reset then idle → count_out=0, request_out=0, fu_ready_out=1, cdb_valid_out=0 for 5 cycles.
- Push tag=0x05 data=0xDEAD0001 at t0; grant_in=1 at t2 → request_out=1 at t1 only; at t2 cdb_valid_out=1, tag=0x05, data=0xDEAD0001; count_out=0 at t3.
- Push tags 0x01 and 0x02 back-to-back (DEPTH=2); grant_in held low → fu_ready_out=0 and request_out stays 1. A third push of 0x03 while full is dropped (assertion). Grants at t3 and t4 → tags 0x01 then 0x02 presented; 0x03 never appears.
- Full buffer, push of 0x07 and grant in the same cycle → push rejected (ready=0); count goes 2→1; head presented. Next cycle push 0x07 accepted; count stays 2. Verify pointer wrap over 6 such cycles with FIFO order kept.
- Buffer holding 2 entries with request in flight; squash=1 together with grant_in=1 → presentation this cycle still valid (combinational). Next cycle count_out=0, request_out=0, and a subsequent grant_in=1 gives cdb_valid_out=0 plus the spurious-grant assertion.
- With CDB_RESULT_BUFFER_BYPASS_EN: push tag=0x0A into an empty buffer at t0 → request_out=1 at t0; grant_in=1 at t1 → cdb_valid_out=1, tag=0x0A at t1. Without the macro, the same stimulus gives request_out=1 at t1 and presentation at t2.
